load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_W, default 32, memory and register data width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_W, default 9, byte address width.
REQ-003 Parameter TIMEOUT, default 15, maximum number of mem_req cycles without mem_ack.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req_valid  input  1  request from core.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RISC-V size code: 000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (DATA_W=64 only).
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  DATA_W  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle response pulse.
REQ-013 resp_rdata  output  DATA_W  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned, illegal size, or timeout; valid with resp_valid.
REQ-015 mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-016 mem_addr  output  ADDR_W  lane-aligned address; low log2(DATA_W/8) bits zero.
REQ-017 mem_be  output  DATA_W/8  byte enables.
REQ-018 mem_wdata  output  DATA_W  lane-positioned store data.
REQ-019 mem_ack  input  1  memory completion; read data valid in the same cycle.
REQ-020 mem_rdata  input  DATA_W  read data.

Function
REQ-021 The FSM SHALL have the states IDLE, MEM and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 On accept (req_valid && req_ready), the unit SHALL register we, funct3, addr and wdata.
REQ-023 Illegal funct3 (any code not listed for the DATA_W), or stores with funct3 of 100, 101 or 110, SHALL be an error.
REQ-024 A misaligned access (H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0) SHALL be an error.
REQ-025 On an error detected at accept, the FSM SHALL go IDLE->RESP, assert no mem_req, and drive resp_err=1 in the next cycle.
REQ-026 For a legal request, the FSM SHALL go IDLE->MEM and hold mem_req=1 from the cycle after accept until the mem_ack cycle inclusive.
REQ-027 mem_addr, mem_we, mem_be and mem_wdata SHALL stay stable while mem_req=1.
REQ-028 Byte lane SHALL be off = addr mod (DATA_W/8); mem_be SHALL be 1 (B), 2'b11 (H), 4'hF (W) or all ones (D), each shifted left by off.
REQ-029 mem_wdata SHALL be the low size bytes of wdata shifted left by off*8, with unused lanes 0; mem_wdata SHALL be 0 for loads.
REQ-030 When mem_ack is seen in MEM, the FSM SHALL go to RESP; resp_valid SHALL be 1 for exactly one cycle in RESP, then the FSM SHALL return to IDLE.
REQ-031 Load result SHALL be the mem_rdata bytes at off, sign-extended (B/H/W) or zero-extended (BU/HU/WU) to DATA_W, registered on the mem_ack cycle.
REQ-032 Best-case latency: accept at cycle t, mem_req at t+1, mem_ack at t+1, resp_valid at t+2; req_ready returns at t+3.
REQ-033 A wait counter SHALL count mem_req cycles without mem_ack; at TIMEOUT cycles, the unit SHALL drop mem_req and go to RESP with resp_err=1.
REQ-034 mem_ack arriving on the same cycle the counter reaches TIMEOUT SHALL win, giving a normal response.
REQ-035 mem_ack outside MEM SHALL be ignored.
REQ-036 req_valid outside IDLE SHALL be ignored; the core SHALL hold the request until accepted.

Reset
REQ-037 reset SHALL force IDLE, the counter to 0, and req_ready=1; all other outputs SHALL be 0 from the cycle after reset is sampled.
REQ-038 reset in MEM or RESP SHALL abort the transaction; no resp_valid SHALL follow, and mem_req SHALL be low the next cycle.

Verification
REQ-039 LB addr=0x003, mem_rdata=0x80FF_1234, ack on the first cycle: mem_addr=0x000, mem_be=4'b1000, resp_rdata=0xFFFF_FF80, resp_valid at t+2.
REQ-040 SH addr=0x006, wdata=0xDEAD_BEEF: mem_be=4'b1100, mem_wdata=0xBEEF_0000, mem_we=1, resp_err=0.
REQ-041 LW addr=0x005: no mem_req, resp_valid at t+1 with resp_err=1 and resp_rdata=0.
REQ-042 LHU addr=0x002, ack delayed 5 cycles, mem_rdata=0x9ABC_0000: mem_req high for 6 cycles, resp_rdata=0x0000_9ABC.
REQ-043 Load with no ack, TIMEOUT=15: mem_req high exactly 15 cycles, then resp_err=1; a second ack-on-15th-cycle case gives resp_err=0.
REQ-044 reset asserted on the third mem_req cycle: no resp_valid; req_ready=1 the cycle after reset is released.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bridge from a RISC-V core to a lane-based memory
// Ports: clk/reset (sync, active-high); req_* core request with req_ready handshake;
// resp_valid/resp_rdata/resp_err one-cycle response; mem_req/mem_we/mem_addr/mem_be/mem_wdata
// to memory with mem_ack/mem_rdata completion.
module load_store_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = $clog2(DATA_W);
  localparam int CW   = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  state_t              state_q, state_d;
  logic                we_q, we_d, err_q, err_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OFFW-1:0]     off;
  logic [1:0]          sz;
  logic [NB-1:0]       be_base;
  logic [DATA_W-1:0]   dmask, shifted, ext;
  logic                sign, illegal, misaligned, req_err;
  assign off = addr_q[OFFW-1:0];
  assign sz  = f3_q[1:0];
  // contiguous run of 2**sz byte enables starting at lane 0
  assign be_base = NB'((32'd1 << (32'd1 << sz)) - 32'd1);
  always_comb begin
    dmask = '0;
    for (int i = 0; i < NB; i++) dmask[8*i +: 8] = {8{be_base[i]}};
  end
  assign shifted = mem_rdata >> {off, 3'b000};
  assign sign    = ~f3_q[2] & shifted[IW'((32'd8 << sz) - 32'd1)];
  assign ext     = (shifted & dmask) | ({DATA_W{sign}} & ~dmask);
  assign illegal = (req_funct3 == 3'b111) ||
                   (DATA_W != 64 && (req_funct3 == 3'b011 || req_funct3 == 3'b110)) ||
                   (req_we && req_funct3[2]);
  assign misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'd2 && |req_addr[1:0]) ||
                      (req_funct3[1:0] == 2'd3 && |req_addr[2:0]);
  assign req_err = illegal || misaligned;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign mem_req    = state_q == MEM;
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_be     = mem_req ? be_base << off : '0;
  assign mem_wdata  = mem_we ? (wdata_q & dmask) << {off, 3'b000} : '0;
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        rdata_d = '0;
        cnt_d   = '0;
        err_d   = req_err;
        state_d = req_err ? RESP : MEM;
      end
      // an ack in the same cycle the counter would expire takes priority
      MEM: if (mem_ack) begin
        rdata_d = we_q ? '0 : ext;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q + 1'b1 == CW'(TIMEOUT)) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = RESP;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit (DATA_W=32, TIMEOUT=15)
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0, resp_rdata, mem_wdata, mem_rdata = '0;
  logic        resp_valid, resp_err, mem_req, mem_we, mem_ack = 1'b0;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  int          n_chk = 0, n_fail = 0, cycles;
  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
    chk("ready_before_issue", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    step;
    req_valid = 1'b0; req_wdata = 32'h5555_5555;
  endtask
  task automatic run_imm(input string tag, input logic we, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input logic [8:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    issue(we, f3, a, wd);
    chk({tag, "_mem_req"}, mem_req, 1'b1);
    chk({tag, "_ready_low"}, req_ready, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, exp_addr);
    chk({tag, "_mem_be"}, mem_be, exp_be);
    chk({tag, "_mem_we"}, mem_we, we);
    chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
    mem_ack = 1'b1; mem_rdata = rd;
    step;
    mem_ack = 1'b0; mem_rdata = '0;
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_resp_err"}, resp_err, 1'b0);
    chk({tag, "_resp_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_mem_req_drop"}, mem_req, 1'b0);
    step;
    chk({tag, "_resp_one_cycle"}, resp_valid, 1'b0);
    chk({tag, "_ready_back"}, req_ready, 1'b1);
  endtask
  task automatic run_err(input string tag, input logic we, input logic [2:0] f3, input logic [8:0] a);
    issue(we, f3, a, 32'hFFFF_FFFF);
    chk({tag, "_no_mem_req"}, mem_req, 1'b0);
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_resp_err"}, resp_err, 1'b1);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    step;
    chk({tag, "_ready_back"}, req_ready, 1'b1);
  endtask
  task automatic wait_load(input string tag, input int ack_at, input logic [31:0] rd, input int exp_cycles,
                           input logic exp_err, input logic [31:0] exp_rd);
    cycles = 0;
    while (mem_req && cycles < 50) begin
      cycles++;
      if (cycles == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
      step;
      mem_ack = 1'b0; mem_rdata = '0;
    end
    chk({tag, "_req_cycles"}, cycles, exp_cycles);
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_resp_err"}, resp_err, exp_err);
    chk({tag, "_resp_rdata"}, resp_rdata, exp_rd);
    step;
    chk({tag, "_ready_back"}, req_ready, 1'b1);
  endtask
  initial begin
    step;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_outputs", {resp_valid, resp_err, mem_req, mem_we, mem_be, mem_addr}, '0);
    reset = 1'b0;
    step;
    run_imm("lb",  1'b0, 3'b000, 9'h003, 32'h0, 32'h80FF_1234, 9'h000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    run_imm("sh",  1'b1, 3'b001, 9'h006, 32'hDEAD_BEEF, 32'h0, 9'h004, 4'b1100, 32'hBEEF_0000, 32'h0);
    run_imm("sb",  1'b1, 3'b000, 9'h0A1, 32'h1234_56A5, 32'h0, 9'h0A0, 4'b0010, 32'h0000_A500, 32'h0);
    run_imm("lh",  1'b0, 3'b001, 9'h010, 32'h0, 32'h7777_8001, 9'h010, 4'b0011, 32'h0, 32'hFFFF_8001);
    run_imm("lbu", 1'b0, 3'b100, 9'h002, 32'h0, 32'h12F0_3456, 9'h000, 4'b0100, 32'h0, 32'h0000_00F0);
    run_imm("sw",  1'b1, 3'b010, 9'h1FC, 32'hCAFE_F00D, 32'h0, 9'h1FC, 4'b1111, 32'hCAFE_F00D, 32'h0);
    run_err("lw_misaligned", 1'b0, 3'b010, 9'h005);
    run_err("lh_misaligned", 1'b0, 3'b001, 9'h001);
    run_err("sbu_store",     1'b1, 3'b100, 9'h000);
    run_err("ld_on_32",      1'b0, 3'b011, 9'h000);
    run_err("f3_111",        1'b0, 3'b111, 9'h000);
    issue(1'b0, 3'b101, 9'h002, 32'h0);
    chk("lhu_mem_be", mem_be, 4'b1100);
    chk("lhu_mem_addr", mem_addr, 9'h000);
    wait_load("lhu_delay", 6, 32'h9ABC_0000, 6, 1'b0, 32'h0000_9ABC);
    issue(1'b0, 3'b010, 9'h040, 32'h0);
    wait_load("timeout", 0, 32'h0, 15, 1'b1, 32'h0);
    issue(1'b0, 3'b010, 9'h040, 32'h0);
    wait_load("ack_on_15", 15, 32'h1234_5678, 15, 1'b0, 32'h1234_5678);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step;
    step;
    chk("stray_ack_no_resp", resp_valid, 1'b0);
    chk("stray_ack_ready", req_ready, 1'b1);
    mem_ack = 1'b0; mem_rdata = '0;
    issue(1'b0, 3'b010, 9'h000, 32'h0);
    step;
    step;
    chk("abort_third_req", mem_req, 1'b1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("abort_mem_req_low", mem_req, 1'b0);
    chk("abort_ready", req_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      step;
      chk("abort_no_resp", resp_valid, 1'b0);
    end
    mem_ack = 1'b0;
    run_imm("after_abort", 1'b0, 3'b010, 9'h008, 32'h0, 32'h0BAD_F00D, 9'h008, 4'b1111, 32'h0, 32'h0BAD_F00D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
